// File: rtl/divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
interface divider_if #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 16
);
    logic                      start;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVISOR_WIDTH-1:0]  divisor;
    logic [DIVIDEND_WIDTH-1:0] quotient;
    logic [DIVISOR_WIDTH-1:0]  remainder;
    logic                      overflow;
    logic                      busy;
    logic                      done;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, overflow, busy, done
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, overflow, busy, done
    );
endinterface

// File: rtl/divider.sv
// Radix-2 restoring divider, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
//
// state    | meaning
// S_IDLE   | waiting for start; operands sampled here
// S_RUN    | one shift/trial-subtract per cycle, DIVIDEND_WIDTH cycles
// S_FINISH | register results, raise done on the next edge
module divider #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    divider_if.slave bus
);
    localparam int CW = $clog2(DIVIDEND_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q;
    logic [DIVIDEND_WIDTH-1:0] dq;
    logic [DIVISOR_WIDTH-1:0]  dvs_q;
    logic [DIVISOR_WIDTH-1:0]  rem_q;
    logic                      zero_q;
    logic                      load, step, finish, busy_c;
    logic                      div_zero;
    logic [DIVISOR_WIDTH:0]    shifted;
    logic                      ge;
    logic [DIVISOR_WIDTH-1:0]  rem_d;
    logic [DIVIDEND_WIDTH-1:0] load_dvd, q_fin;
    logic [DIVISOR_WIDTH-1:0]  load_dvs, r_fin;
    logic                      ovf_fin;

    assign div_zero = (bus.divisor == '0);

`ifdef DIVIDER_SIGNED_EN
    logic neg_q, rneg_q, ovf_q;
    logic dvd_neg, dvs_neg;

    assign dvd_neg  = bus.dividend[DIVIDEND_WIDTH-1];
    assign dvs_neg  = bus.divisor[DIVISOR_WIDTH-1];
    // Divide-by-zero keeps the raw dividend so its low bits become the remainder.
    assign load_dvd = (dvd_neg && !div_zero) ? -bus.dividend : bus.dividend;
    assign load_dvs = dvs_neg ? -bus.divisor : bus.divisor;
    assign q_fin    = neg_q  ? -dq    : dq;
    assign r_fin    = rneg_q ? -rem_q : rem_q;
    assign ovf_fin  = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load) begin
            neg_q  <= dvd_neg ^ dvs_neg;
            rneg_q <= dvd_neg;
            ovf_q  <= dvd_neg && (bus.dividend[DIVIDEND_WIDTH-2:0] == '0) && (bus.divisor == '1);
        end
    end
`else
    assign load_dvd = bus.dividend;
    assign load_dvs = bus.divisor;
    assign q_fin    = dq;
    assign r_fin    = rem_q;
    assign ovf_fin  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        busy_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = div_zero ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                step   = 1'b1;
                busy_c = 1'b1;
                if (cnt_q == CW'(1)) state_d = S_FINISH;
            end
            S_FINISH: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy = busy_c;

    // Partial remainder stays below the divisor, so only the shifted value needs the extra bit.
    always_comb begin
        shifted = {rem_q, dq[DIVIDEND_WIDTH-1]};
        ge      = (shifted >= {1'b0, dvs_q});
        rem_d   = ge ? DIVISOR_WIDTH'(shifted - {1'b0, dvs_q}) : shifted[DIVISOR_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dq     <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            zero_q <= 1'b0;
        end else if (load) begin
            cnt_q  <= CW'(DIVIDEND_WIDTH);
            dq     <= load_dvd;
            dvs_q  <= load_dvs;
            rem_q  <= '0;
            zero_q <= div_zero;
        end else if (step) begin
            cnt_q <= cnt_q - CW'(1);
            dq    <= {dq[DIVIDEND_WIDTH-2:0], ge};
            rem_q <= rem_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.overflow  <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= finish;
            if (finish) begin
                bus.quotient  <= zero_q ? '1 : q_fin;
                bus.remainder <= zero_q ? dq[DIVISOR_WIDTH-1:0] : r_fin;
                bus.overflow  <= zero_q | ovf_fin;
            end
        end
    end
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases plus random operands against an arithmetic model.
module tb_divider;
    localparam int DW = 32;
    localparam int SW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    divider_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW)) bus ();
    divider #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total  = 0;
    int passes = 0;
    logic [DW-1:0] last_q;
    logic [SW-1:0] last_r;
    logic          last_ov;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void model(input logic [DW-1:0] a, input logic [SW-1:0] b,
                                  output logic [DW-1:0] q, output logic [SW-1:0] r,
                                  output logic ov);
        if (b == '0) begin
            q  = '1;
            r  = a[SW-1:0];
            ov = 1'b1;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            longint sa, sb;
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            if (sa == -(longint'(1) << (DW - 1)) && sb == -1) begin
                q  = DW'(sa);
                r  = '0;
                ov = 1'b1;
            end else begin
                q  = DW'(sa / sb);
                r  = SW'(sa % sb);
                ov = 1'b0;
            end
`else
            longint unsigned ua, ub;
            ua = longint'(a);
            ub = longint'(b);
            q  = DW'(ua / ub);
            r  = SW'(ua % ub);
            ov = 1'b0;
`endif
        end
    endfunction

    // Called at a falling edge; start is driven now and sampled by the next rising edge.
    task automatic run_op(input logic [DW-1:0] a, input logic [SW-1:0] b, input int ign_at);
        logic [DW-1:0] eq;
        logic [SW-1:0] er;
        logic          eov;
        int            lat;
        int            exp_lat;
        model(a, b, eq, er, eov);
        exp_lat = (b == '0) ? 2 : DW + 2;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = SW'($urandom);
        lat = 1;
        chk("busy_running", 64'(bus.busy), 64'(b != '0));
        chk("hold_quotient", 64'(bus.quotient), 64'(last_q));
        chk("hold_remainder", 64'(bus.remainder), 64'(last_r));
        while (!bus.done && lat < 100) begin
            if (lat == ign_at) begin
                bus.start    = 1'b1;
                bus.dividend = 7;
                bus.divisor  = 3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("quotient", 64'(bus.quotient), 64'(eq));
        chk("remainder", 64'(bus.remainder), 64'(er));
        chk("overflow", 64'(bus.overflow), 64'(eov));
        chk("busy_at_done", 64'(bus.busy), 64'd0);
        last_q  = eq;
        last_r  = er;
        last_ov = eov;
    endtask

    initial begin
        int sel;
        int gap;
        logic [DW-1:0] ra;
        logic [SW-1:0] rb;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        last_q  = '0;
        last_r  = '0;
        last_ov = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_quotient", 64'(bus.quotient), 64'd0);
        chk("rst_remainder", 64'(bus.remainder), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'd100, 16'd10, 0);
`ifndef DIVIDER_SIGNED_EN
        chk("q_100_10", 64'(bus.quotient), 64'd10);
`endif
        run_op(32'd50, 16'd0, 0);
        chk("r_50_0", 64'(bus.remainder), 64'd50);
        run_op(32'hFFFF_FFFF, 16'd1, 0);
        run_op(32'd10, 16'd100, 0);
        run_op(32'd2, 16'hFFFF, 0);
        run_op(32'd0, 16'd12345, 0);
        run_op(32'h7FFF_FFFF, 16'd2, 5);
        run_op(32'hFFFF_FFCE, 16'hFFF6, 0);
        run_op(32'd50, 16'hFFF6, 0);
        run_op(32'hFFFF_FFF9, 16'd2, 0);
        run_op(32'h8000_0000, 16'hFFFF, 0);
        run_op(32'h8000_0000, 16'h8000, 0);

        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 9));
            ra  = (sel > 6) ? DW'($urandom_range(0, 300)) : DW'($urandom);
            if (sel == 0)     rb = '0;
            else if (sel < 4) rb = SW'($urandom_range(1, 15));
            else              rb = SW'($urandom);
            run_op(ra, rb, (i % 5 == 0) ? 9 : 0);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                repeat (gap) @(negedge clk);
                chk("done_pulse", 64'(bus.done), 64'd0);
            end
        end

        bus.start    = 1'b1;
        bus.dividend = 32'd12345678;
        bus.divisor  = 16'd1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_quotient", 64'(bus.quotient), 64'd0);
        chk("abort_remainder", 64'(bus.remainder), 64'd0);
        chk("abort_overflow", 64'(bus.overflow), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        last_q  = '0;
        last_r  = '0;
        last_ov = 1'b0;
        @(negedge clk);

        run_op(32'hFFFF_FFCE, 16'd10, 0);
`ifdef DIVIDER_SIGNED_EN
        chk("q_m50_10", 64'(bus.quotient), 64'hFFFF_FFFB);
        chk("r_m50_10", 64'(bus.remainder), 64'd0);
`else
        chk("q_m50_10", 64'(bus.quotient), 64'd429496724);
        chk("r_m50_10", 64'(bus.remainder), 64'd6);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/divider.md
Name: divider

Overview:
- Sequential radix-2 restoring integer divider: one quotient bit per clock.
- Unsigned by default. Divides a DIVIDEND_WIDTH-bit dividend by a DIVISOR_WIDTH-bit divisor, giving a full-width quotient, a divisor-width remainder and a divide-by-zero flag.
- Used in the FM radio datapath wherever a non-constant division is needed off the critical path.

Parameters:
- DIVIDEND_WIDTH, 32, width of dividend and quotient (>= 2).
- DIVISOR_WIDTH, 16, width of divisor and remainder (>= 2, <= DIVIDEND_WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; operands sampled when idle.
- dividend  in  DIVIDEND_WIDTH  numerator.
- divisor  in  DIVISOR_WIDTH  denominator.
- quotient  out  DIVIDEND_WIDTH  result, held until next completion.
- remainder  out  DIVISOR_WIDTH  result, held until next completion.
- overflow  out  1  high when the last completed operation was invalid (divide by zero).
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when quotient/remainder/overflow update.

Behaviour:
- Reset (async assert, sync release): state IDLE; quotient, remainder, overflow, busy, done all 0; iteration counter 0.
- States: IDLE, RUN, FINISH.
- IDLE, start=1 and divisor!=0:
  - latch dividend into shift register and divisor; clear the partial remainder (DIVISOR_WIDTH+1 bits); load counter with DIVIDEND_WIDTH; go to RUN; busy=1.
- IDLE, start=1 and divisor==0:
  - go to FINISH directly.
  - Result: quotient = all ones, remainder = dividend[DIVISOR_WIDTH-1:0], overflow = 1.
- RUN, each cycle:
  - shift the partial remainder left, bringing in the dividend MSB.
  - trial-subtract the divisor; if the result is non-negative, keep it and shift 1 into the quotient, else shift 0.
  - decrement the counter; after DIVIDEND_WIDTH iterations go to FINISH.
- FINISH:
  - register quotient/remainder/overflow (overflow=0 on the normal path); pulse done=1 for one cycle; busy=0; return to IDLE.
- Latency: start sampled at edge N.
  - Normal: done high in the cycle after edge N+DIVIDEND_WIDTH+1 (34 cycles at defaults).
  - Divide by zero: done high after edge N+1.
- start while busy: ignored; no queuing; operands are not re-sampled.
- start in the done cycle is accepted: FINISH returns to IDLE, and IDLE samples start on the following edge.
- Operand changes after the sampling edge have no effect on the current operation.
- Outputs are stable from done until the next done; they are not cleared by start.
- Reset mid-operation: abort immediately, all outputs to reset values.
- Unsigned mode: inputs are raw bit patterns; negative literals are treated as large unsigned values.
- Remainder is always < divisor, so it fits DIVISOR_WIDTH.
- Quotient never exceeds DIVIDEND_WIDTH, so overflow only flags divide-by-zero in unsigned mode.

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined: operands are two's complement.
  - Take absolute values at start and run the same unsigned core.
  - Negate the quotient if the operand signs differ; the remainder takes the dividend's sign (truncation toward zero).
  - Extra overflow case: dividend = most negative value and divisor = -1. Result is quotient = most negative value, remainder 0, overflow=1, normal latency.
  - Divide by zero: quotient all ones, remainder = dividend low bits, overflow=1.
- Not defined: unsigned behaviour as above; no sign logic synthesized.

Test Plan:
- 100/10 -> done after 34 cycles; quotient 10, remainder 0, overflow 0.
- 50/0 -> done after 2 cycles; quotient 0xFFFFFFFF, remainder 50, overflow 1.
- 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0, overflow 0.
- 10/100 -> quotient 0, remainder 10; 2/0xFFFF -> quotient 0, remainder 2; 0/12345 -> quotient 0, remainder 0.
- 0x7FFFFFFF/2 -> quotient 0x3FFFFFFF, remainder 1. Pulse start again mid-operation with 7/3 -> ignored, first result unchanged.
- 12345678/1 started, rst_n low at cycle 10 -> all outputs 0, busy 0.
- Then -50/10 unsigned (0xFFFFFFCE/10) -> quotient 429496724, remainder 6.
- With DIVIDER_SIGNED_EN: -50/10 -> quotient -5, remainder 0; 50/-10 -> quotient -5; -50/-10 -> quotient 5; -7/2 -> quotient -3, remainder -1.
